xor_frame_sequencer: RTL and testbench

Controller that sequences the XOR-cipher datapath between UART_Receiver and UART_Sender. It receives a length-prefixed data frame and a length-prefixed key frame, then XORs each data byte with the repeating key at one byte per cycle. It returns the length byte followed by the ciphertext over the UART, and exposes both buffers through a read port for the LED display. It replaces the ad-hoc receive, encrypt and transmit logic in the top level with one FSM.

---
 rtl/dea_pkg.sv | 27 ++
 rtl/dea_tx_pump.sv | 70 +++++++
 rtl/xor_frame_sequencer.sv | 192 +++++++++++++++++++
 tb/tb_xor_frame_sequencer.sv | 318 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dea_pkg.sv
// Shared types and constants for the XOR frame sequencer: FSM encodings,
// transmit pump phases, default buffer depths and the header-select flag.
package dea_pkg;

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_RX_DATA  = 3'd1,
    S_RX_KLEN  = 3'd2,
    S_RX_KEY   = 3'd3,
    S_ENC      = 3'd4,
    S_TX_LOAD  = 3'd5,
    S_TX_ACK   = 3'd6,
    S_TX_DRAIN = 3'd7
  } state_t;

  typedef enum logic [1:0] {
    P_LOAD  = 2'd0,
    P_ACK   = 2'd1,
    P_DRAIN = 2'd2
  } pump_t;

  localparam int   DATA_DEPTH_DEF = 100;
  localparam int   KEY_DEPTH_DEF  = 4;
  // Set while the byte pointer addresses the length header instead of result[].
  localparam logic HDR_BYTE_SEL   = 1'b1;

endpackage

// File: rtl/dea_tx_pump.sv
// Single-byte UART sender handshake: wait for idle, strobe the byte out,
// wait for the sender to pick it up, then wait for it to finish.
module dea_tx_pump
  import dea_pkg::*;
(
  input  logic       clk_i,
  input  logic       rst_n_i,
  input  logic       start_i,
  input  logic [7:0] byte_i,
  input  logic       tx_busy_i,
  output logic [7:0] tx_data_o,
  output logic       tx_send_o,
  output logic       sent_o,
  output logic       acked_o,
  output logic       done_o
);

  pump_t      ph_q, ph_d;
  logic [7:0] data_q, data_d;
  logic       send_q, send_d;

  always_comb begin
    ph_d    = ph_q;
    data_d  = data_q;
    send_d  = 1'b0;
    sent_o  = 1'b0;
    acked_o = 1'b0;
    done_o  = 1'b0;
    case (ph_q)
      P_LOAD: begin
        // A sender that is already busy gets no strobe until it goes idle.
        if (start_i && !tx_busy_i) begin
          send_d = 1'b1;
          data_d = byte_i;
          sent_o = 1'b1;
          ph_d   = P_ACK;
        end
      end
      P_ACK: begin
        if (tx_busy_i) begin
          acked_o = 1'b1;
          ph_d    = P_DRAIN;
        end
      end
      P_DRAIN: begin
        if (!tx_busy_i) begin
          done_o = 1'b1;
          ph_d   = P_LOAD;
        end
      end
      default: ph_d = P_LOAD;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      ph_q   <= P_LOAD;
      data_q <= 8'h00;
      send_q <= 1'b0;
    end else begin
      ph_q   <= ph_d;
      data_q <= data_d;
      send_q <= send_d;
    end
  end

  assign tx_data_o = data_q;
  assign tx_send_o = send_q;

endmodule

// File: rtl/xor_frame_sequencer.sv
// Receives a length-prefixed data frame and key frame, XORs the data with the
// repeating key one byte per cycle, and sends length + ciphertext back out.
module xor_frame_sequencer
  import dea_pkg::*;
#(
  parameter int DATA_DEPTH = DATA_DEPTH_DEF,
  parameter int KEY_DEPTH  = KEY_DEPTH_DEF
) (
  input  logic       Clk_100M,
  input  logic       Reset_n,
  input  logic [7:0] Rx_Data,
  input  logic       Rx_Ready,
  output logic       Rx_Ack,
  output logic [7:0] Tx_Data,
  output logic       Tx_Send,
  input  logic       Tx_Busy,
  input  logic [7:0] ViewIndex,
  output logic [7:0] ViewData,
  output logic [7:0] ViewResult,
  output logic       Busy,
  output logic       FrameDone,
  output logic       Err
);

  localparam int         AW      = (DATA_DEPTH > 1) ? $clog2(DATA_DEPTH) : 1;
  localparam int         KW      = (KEY_DEPTH > 1) ? $clog2(KEY_DEPTH) : 1;
  localparam logic [7:0] DEPTH8  = 8'(DATA_DEPTH);
  localparam logic [7:0] KDEPTH8 = 8'(KEY_DEPTH);

  logic [7:0] user_data [DATA_DEPTH];
  logic [7:0] result    [DATA_DEPTH];
  logic [7:0] keys      [KEY_DEPTH];

  state_t     state_q, state_d;
  logic [7:0] len_q, len_d, klen_q, klen_d;
  logic [7:0] i_q, i_d, k_q, k_d;
  logic       hdr_q, hdr_d;
  logic       ack_q, ack_d, err_q, err_d, done_q, done_d;
  logic       wr_data, wr_key, wr_res;
  logic       rx_active, accept;
  logic       tx_sent, tx_acked, tx_done;
  logic [7:0] tx_byte;

  assign rx_active = (state_q == S_IDLE) || (state_q == S_RX_DATA) ||
                     (state_q == S_RX_KLEN) || (state_q == S_RX_KEY);
  assign accept    = rx_active && Rx_Ready && !ack_q;

  always_comb begin
    state_d = state_q;
    len_d   = len_q;
    klen_d  = klen_q;
    i_d     = i_q;
    k_d     = k_q;
    hdr_d   = hdr_q;
    ack_d   = ack_q;
    err_d   = 1'b0;
    done_d  = 1'b0;
    wr_data = 1'b0;
    wr_key  = 1'b0;
    wr_res  = 1'b0;
    // Ack is held until the receiver drops Ready, whatever state we are in.
    if (accept)         ack_d = 1'b1;
    else if (!Rx_Ready) ack_d = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (accept) begin
          if (Rx_Data == 8'h00) begin
            state_d = S_IDLE;
          end else if (Rx_Data > DEPTH8) begin
            err_d = 1'b1;
          end else begin
            len_d   = Rx_Data;
            i_d     = 8'h00;
            state_d = S_RX_DATA;
          end
        end
      end
      S_RX_DATA: begin
        if (accept) begin
          wr_data = 1'b1;
          if (i_q == len_q - 8'd1) state_d = S_RX_KLEN;
          else                     i_d     = i_q + 8'd1;
        end
      end
      S_RX_KLEN: begin
        if (accept) begin
          if (Rx_Data == 8'h00 || Rx_Data > KDEPTH8) begin
            err_d   = 1'b1;
            state_d = S_IDLE;
          end else begin
            klen_d  = Rx_Data;
            k_d     = 8'h00;
            state_d = S_RX_KEY;
          end
        end
      end
      S_RX_KEY: begin
        if (accept) begin
          wr_key = 1'b1;
          if (k_q == klen_q - 8'd1) begin
            i_d     = 8'h00;
            k_d     = 8'h00;
            state_d = S_ENC;
          end else begin
            k_d = k_q + 8'd1;
          end
        end
      end
      S_ENC: begin
        wr_res = 1'b1;
        k_d    = (k_q == klen_q - 8'd1) ? 8'h00 : k_q + 8'd1;
        if (i_q == len_q - 8'd1) begin
          i_d     = 8'h00;
          hdr_d   = HDR_BYTE_SEL;
          state_d = S_TX_LOAD;
        end else begin
          i_d = i_q + 8'd1;
        end
      end
      S_TX_LOAD:  if (tx_sent)  state_d = S_TX_ACK;
      S_TX_ACK:   if (tx_acked) state_d = S_TX_DRAIN;
      S_TX_DRAIN: begin
        if (tx_done) begin
          if (hdr_q != HDR_BYTE_SEL && i_q == len_q - 8'd1) begin
            done_d  = 1'b1;
            i_d     = 8'h00;
            state_d = S_IDLE;
          end else begin
            if (hdr_q == HDR_BYTE_SEL) hdr_d = ~HDR_BYTE_SEL;
            else                       i_d   = i_q + 8'd1;
            state_d = S_TX_LOAD;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge Clk_100M) begin
    if (!Reset_n) begin
      state_q <= S_IDLE;
      len_q   <= 8'h00;
      klen_q  <= 8'h00;
      i_q     <= 8'h00;
      k_q     <= 8'h00;
      hdr_q   <= 1'b0;
      ack_q   <= 1'b0;
      err_q   <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      len_q   <= len_d;
      klen_q  <= klen_d;
      i_q     <= i_d;
      k_q     <= k_d;
      hdr_q   <= hdr_d;
      ack_q   <= ack_d;
      err_q   <= err_d;
      done_q  <= done_d;
    end
  end

  // Buffers keep the last frame for the display and are never cleared.
  always_ff @(posedge Clk_100M) begin
    if (wr_data) user_data[i_q[AW-1:0]] <= Rx_Data;
    if (wr_key)  keys[k_q[KW-1:0]]      <= Rx_Data;
    if (wr_res)  result[i_q[AW-1:0]]    <= user_data[i_q[AW-1:0]] ^ keys[k_q[KW-1:0]];
  end

  assign tx_byte = (hdr_q == HDR_BYTE_SEL) ? len_q : result[i_q[AW-1:0]];

  dea_tx_pump u_pump (
    .clk_i     (Clk_100M),
    .rst_n_i   (Reset_n),
    .start_i   (state_q == S_TX_LOAD),
    .byte_i    (tx_byte),
    .tx_busy_i (Tx_Busy),
    .tx_data_o (Tx_Data),
    .tx_send_o (Tx_Send),
    .sent_o    (tx_sent),
    .acked_o   (tx_acked),
    .done_o    (tx_done)
  );

  assign ViewData   = (ViewIndex < DEPTH8) ? user_data[ViewIndex[AW-1:0]] : 8'h00;
  assign ViewResult = (ViewIndex < DEPTH8) ? result[ViewIndex[AW-1:0]]    : 8'h00;
  assign Rx_Ack     = ack_q;
  assign Busy       = (state_q != S_IDLE);
  assign FrameDone  = done_q;
  assign Err        = err_q;

endmodule

// File: tb/tb_xor_frame_sequencer.sv
// Scoreboard bench for xor_frame_sequencer: a UART sender model pops expected
// transmit bytes on every Tx_Send strobe; tasks drive receive frames.
module tb_xor_frame_sequencer;

  logic       Clk_100M;
  logic       Reset_n;
  logic [7:0] Rx_Data;
  logic       Rx_Ready;
  logic       Rx_Ack;
  logic [7:0] Tx_Data;
  logic       Tx_Send;
  logic       Tx_Busy;
  logic [7:0] ViewIndex;
  logic [7:0] ViewData;
  logic [7:0] ViewResult;
  logic       Busy;
  logic       FrameDone;
  logic       Err;

  int total = 0;
  int bad   = 0;
  int n_send = 0;
  int n_done = 0;
  int n_err  = 0;
  int busy_left = 0;
  bit force_busy = 1'b0;
  logic [7:0] exp_q[$];

  xor_frame_sequencer #(.DATA_DEPTH(100), .KEY_DEPTH(4)) dut (
    .Clk_100M  (Clk_100M),
    .Reset_n   (Reset_n),
    .Rx_Data   (Rx_Data),
    .Rx_Ready  (Rx_Ready),
    .Rx_Ack    (Rx_Ack),
    .Tx_Data   (Tx_Data),
    .Tx_Send   (Tx_Send),
    .Tx_Busy   (Tx_Busy),
    .ViewIndex (ViewIndex),
    .ViewData  (ViewData),
    .ViewResult(ViewResult),
    .Busy      (Busy),
    .FrameDone (FrameDone),
    .Err       (Err)
  );

  initial begin
    Clk_100M = 1'b0;
    forever #5 Clk_100M = ~Clk_100M;
  end

  // Sender model and output monitor, sampled on the falling edge.
  initial begin
    logic [7:0] e;
    Tx_Busy = 1'b0;
    forever begin
      @(negedge Clk_100M);
      if (FrameDone === 1'b1) n_done++;
      if (Err === 1'b1) n_err++;
      if (Tx_Send === 1'b1) begin
        n_send++;
        total++;
        if (exp_q.size() == 0) begin
          bad++;
          $display("FAIL tx_unexpected got=%02h want=none", Tx_Data);
        end else begin
          e = exp_q.pop_front();
          if (Tx_Data !== e) begin
            bad++;
            $display("FAIL tx_byte got=%02h want=%02h", Tx_Data, e);
          end
        end
        busy_left = 3;
      end else if (busy_left > 0) begin
        busy_left--;
      end
      Tx_Busy = force_busy || (busy_left > 0);
    end
  end

  task automatic send_rx(input logic [7:0] b);
    int t;
    Rx_Data  = b;
    Rx_Ready = 1'b1;
    t = 0;
    while (Rx_Ack !== 1'b1 && t < 50) begin @(negedge Clk_100M); t++; end
    total++;
    if (t >= 50) begin bad++; $display("FAIL rx_ack_rise got=0 want=1 byte=%02h", b); end
    Rx_Ready = 1'b0;
    t = 0;
    while (Rx_Ack !== 1'b0 && t < 50) begin @(negedge Clk_100M); t++; end
    total++;
    if (t >= 50) begin bad++; $display("FAIL rx_ack_fall got=1 want=0 byte=%02h", b); end
  endtask

  task automatic load_frame(input logic [7:0] d[$], input logic [7:0] k[$]);
    exp_q.push_back(8'(d.size()));
    for (int j = 0; j < d.size(); j++) exp_q.push_back(d[j] ^ k[j % k.size()]);
    send_rx(8'(d.size()));
    for (int j = 0; j < d.size(); j++) send_rx(d[j]);
    send_rx(8'(k.size()));
    for (int j = 0; j < k.size(); j++) send_rx(k[j]);
  endtask

  task automatic wait_frame(input string name);
    int d0;
    int t;
    d0 = n_done;
    t  = 0;
    while (n_done == d0 && t < 5000) begin @(negedge Clk_100M); t++; end
    repeat (2) @(negedge Clk_100M);
    total++;
    if (n_done != d0 + 1) begin
      bad++;
      $display("FAIL %s_framedone got=%0d want=%0d", name, n_done - d0, 1);
    end
    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL %s_tx_left got=%0d want=0", name, exp_q.size());
    end
    total++;
    if (Busy !== 1'b0) begin bad++; $display("FAIL %s_busy_end got=%b want=0", name, Busy); end
  endtask

  task automatic check_idle_outputs(input string name);
    total++;
    if (Rx_Ack !== 1'b0)    begin bad++; $display("FAIL %s_rx_ack got=%b want=0", name, Rx_Ack); end
    total++;
    if (Tx_Send !== 1'b0)   begin bad++; $display("FAIL %s_tx_send got=%b want=0", name, Tx_Send); end
    total++;
    if (Tx_Data !== 8'h00)  begin bad++; $display("FAIL %s_tx_data got=%02h want=00", name, Tx_Data); end
    total++;
    if (Busy !== 1'b0)      begin bad++; $display("FAIL %s_busy got=%b want=0", name, Busy); end
    total++;
    if (FrameDone !== 1'b0) begin bad++; $display("FAIL %s_framedone got=%b want=0", name, FrameDone); end
    total++;
    if (Err !== 1'b0)       begin bad++; $display("FAIL %s_err got=%b want=0", name, Err); end
  endtask

  task automatic test_reset();
    Reset_n = 1'b0;
    repeat (3) @(negedge Clk_100M);
    check_idle_outputs("reset");
    Reset_n = 1'b1;
    @(negedge Clk_100M);
  endtask

  task automatic test_normal();
    exp_q.push_back(8'h03);
    exp_q.push_back(8'h51);
    exp_q.push_back(8'h62);
    exp_q.push_back(8'h53);
    send_rx(8'h03); send_rx(8'h41); send_rx(8'h42); send_rx(8'h43);
    send_rx(8'h02); send_rx(8'h10); send_rx(8'h20);
    wait_frame("normal");
    ViewIndex = 8'd1;
    #1;
    total++;
    if (ViewResult !== 8'h62) begin bad++; $display("FAIL view_result got=%02h want=62", ViewResult); end
    total++;
    if (ViewData !== 8'h42)   begin bad++; $display("FAIL view_data got=%02h want=42", ViewData); end
  endtask

  task automatic test_key_wrap();
    logic [7:0] d[$];
    logic [7:0] k[$];
    d = '{8'h00, 8'h01, 8'h02, 8'h03, 8'h04};
    k = '{8'hFF};
    load_frame(d, k);
    wait_frame("keywrap");
  endtask

  task automatic test_illegal();
    int s0;
    int e0;
    s0 = n_send;
    e0 = n_err;
    send_rx(8'h00);
    repeat (2) @(negedge Clk_100M);
    total++;
    if (Busy !== 1'b0) begin bad++; $display("FAIL len0_busy got=%b want=0", Busy); end
    total++;
    if (n_err != e0)   begin bad++; $display("FAIL len0_err got=%0d want=%0d", n_err, e0); end
    send_rx(8'h65);
    repeat (2) @(negedge Clk_100M);
    total++;
    if (n_err != e0 + 1) begin bad++; $display("FAIL len65_err got=%0d want=%0d", n_err, e0 + 1); end
    total++;
    if (Busy !== 1'b0)   begin bad++; $display("FAIL len65_busy got=%b want=0", Busy); end
    send_rx(8'h01);
    total++;
    if (Busy !== 1'b1)   begin bad++; $display("FAIL len1_busy got=%b want=1", Busy); end
    send_rx(8'hAA);
    send_rx(8'h05);
    repeat (2) @(negedge Clk_100M);
    total++;
    if (n_err != e0 + 2) begin bad++; $display("FAIL klen5_err got=%0d want=%0d", n_err, e0 + 2); end
    total++;
    if (Busy !== 1'b0)   begin bad++; $display("FAIL klen5_busy got=%b want=0", Busy); end
    total++;
    if (n_send != s0)    begin bad++; $display("FAIL illegal_tx got=%0d want=%0d", n_send - s0, 0); end
  endtask

  task automatic test_rx_handshake();
    exp_q.push_back(8'h02);
    exp_q.push_back(8'h1E);
    exp_q.push_back(8'h2D);
    Rx_Data  = 8'h02;
    Rx_Ready = 1'b1;
    for (int c = 0; c < 10; c++) begin
      @(negedge Clk_100M);
      total++;
      if (Rx_Ack !== 1'b1) begin bad++; $display("FAIL hold_ack cyc=%0d got=%b want=1", c, Rx_Ack); end
    end
    Rx_Ready = 1'b0;
    total++;
    if (Rx_Ack !== 1'b1) begin bad++; $display("FAIL ack_before_fall got=%b want=1", Rx_Ack); end
    @(negedge Clk_100M);
    total++;
    if (Rx_Ack !== 1'b0) begin bad++; $display("FAIL ack_after_fall got=%b want=0", Rx_Ack); end
    send_rx(8'h11); send_rx(8'h22); send_rx(8'h01); send_rx(8'h0F);
    wait_frame("hold");
  endtask

  task automatic test_enc_no_ack();
    logic [7:0] d[$];
    logic [7:0] k[$];
    for (int j = 0; j < 100; j++) d.push_back(8'($urandom_range(0, 255)));
    k = '{8'h5A, 8'hC3, 8'h01, 8'h80};
    load_frame(d, k);
    Rx_Data  = 8'h07;
    Rx_Ready = 1'b1;
    for (int c = 0; c < 30; c++) begin
      @(negedge Clk_100M);
      total++;
      if (Rx_Ack !== 1'b0) begin bad++; $display("FAIL enc_ack cyc=%0d got=%b want=0", c, Rx_Ack); end
    end
    total++;
    if (Busy !== 1'b1) begin bad++; $display("FAIL enc_busy got=%b want=1", Busy); end
    Rx_Ready = 1'b0;
    wait_frame("max");
    ViewIndex = 8'd99;
    #1;
    total++;
    if (ViewData !== d[99]) begin bad++; $display("FAIL view99_data got=%02h want=%02h", ViewData, d[99]); end
    total++;
    if (ViewResult !== (d[99] ^ k[3])) begin
      bad++;
      $display("FAIL view99_result got=%02h want=%02h", ViewResult, d[99] ^ k[3]);
    end
  endtask

  task automatic test_backpressure();
    logic [7:0] d[$];
    logic [7:0] k[$];
    int s0;
    d = '{8'h9C, 8'h3E, 8'h70};
    k = '{8'h0F, 8'hF0, 8'hAA};
    force_busy = 1'b1;
    s0 = n_send;
    load_frame(d, k);
    repeat (200) @(negedge Clk_100M);
    total++;
    if (n_send != s0) begin bad++; $display("FAIL bp_no_send got=%0d want=0", n_send - s0); end
    total++;
    if (Busy !== 1'b1) begin bad++; $display("FAIL bp_busy got=%b want=1", Busy); end
    force_busy = 1'b0;
    wait_frame("bp");
    total++;
    if (n_send != s0 + 4) begin bad++; $display("FAIL bp_strobes got=%0d want=4", n_send - s0); end
  endtask

  task automatic test_reset_mid();
    logic [7:0] d[$];
    logic [7:0] k[$];
    int s0;
    int t;
    d = '{8'h12, 8'h34, 8'h56, 8'h78};
    k = '{8'hA5, 8'h5A, 8'hFF};
    s0 = n_send;
    load_frame(d, k);
    t = 0;
    while (n_send < s0 + 3 && t < 2000) begin @(negedge Clk_100M); t++; end
    total++;
    if (n_send < s0 + 3) begin bad++; $display("FAIL mid_reach got=%0d want=3", n_send - s0); end
    @(negedge Clk_100M);
    Reset_n = 1'b0;
    @(negedge Clk_100M);
    check_idle_outputs("midreset");
    Reset_n = 1'b1;
    exp_q.delete();
    t = 0;
    while (Tx_Busy !== 1'b0 && t < 100) begin @(negedge Clk_100M); t++; end
    d = '{8'hDE, 8'hAD, 8'hBE, 8'hEF, 8'h00, 8'h01};
    k = '{8'h11, 8'h22};
    load_frame(d, k);
    wait_frame("after_reset");
  endtask

  initial begin
    Reset_n   = 1'b0;
    Rx_Data   = 8'h00;
    Rx_Ready  = 1'b0;
    ViewIndex = 8'h00;
    test_reset();
    test_normal();
    test_key_wrap();
    test_illegal();
    test_rx_handshake();
    test_enc_no_ack();
    test_backpressure();
    test_reset_mid();
    repeat (5) @(negedge Clk_100M);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
